// File: rtl/fft_pair_gen.sv
// Radix-2 DIF pairing stage: buffers the first half of each frame, then emits (x[n], x[n+N/2]) pairs
// with a valid/last tag delayed to match FFT_cadd. Optional align-error counter via FFT_PAIR_ERR_CNT_EN.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

module fft_pair_gen #(
    parameter int FFT_SIZE = 64,
    parameter int CADD_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*`FFT_DATA_WIDTH-1:0]  in_data,
    input  logic                          in_valid,
    input  logic                          in_sop,
    output logic [2*`FFT_DATA_WIDTH-1:0]  opa,
    output logic [2*`FFT_DATA_WIDTH-1:0]  opb,
    output logic                          pair_valid,
    output logic                          pair_last,
    output logic                          sum_valid,
    output logic                          sum_last,
    output logic                          align_err
`ifdef FFT_PAIR_ERR_CNT_EN
    ,
    output logic [15:0]                   align_err_cnt
`endif
);

    localparam int SW   = 2 * `FFT_DATA_WIDTH;
    localparam int HALF = FFT_SIZE / 2;
    localparam int CW   = $clog2(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PAIR = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic          pair_fire;
    logic          err_next;

    logic [SW-1:0] buf_mem [HALF];
    logic [SW-1:0] opa_reg, opb_reg;
    logic          pair_valid_reg, pair_last_reg, align_err_reg;
    logic [CADD_LAT-1:0] dly_valid_reg, dly_last_reg;

    // A qualified sop always restarts the frame; it is an error unless we were idle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_addr    = cnt_reg;
        pair_fire  = 1'b0;
        err_next   = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                wr_en      = 1'b1;
                wr_addr    = '0;
                cnt_next   = CNT_ONE;
                state_next = ST_FILL;
                err_next   = (state_reg != ST_IDLE);
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        err_next = 1'b1;
                    end
                    ST_FILL: begin
                        wr_en = 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            cnt_next   = '0;
                            state_next = ST_PAIR;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    ST_PAIR: begin
                        pair_fire = 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            cnt_next   = '0;
                            state_next = ST_IDLE;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end
        end
    end

    // Buffer is deliberately left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            pair_valid_reg <= 1'b0;
            pair_last_reg  <= 1'b0;
            align_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pair_valid_reg <= pair_fire;
            pair_last_reg  <= pair_fire && (cnt_reg == CNT_LAST);
            align_err_reg  <= err_next;
            if (pair_fire) begin
                opa_reg <= buf_mem[cnt_reg];
                opb_reg <= in_data;
            end
        end
    end

    // Tag delay line matching the downstream adder latency.
    generate
        for (genvar gi = 0; gi < CADD_LAT; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        dly_valid_reg[gi] <= 1'b0;
                        dly_last_reg[gi]  <= 1'b0;
                    end else begin
                        dly_valid_reg[gi] <= pair_valid_reg;
                        dly_last_reg[gi]  <= pair_last_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        dly_valid_reg[gi] <= 1'b0;
                        dly_last_reg[gi]  <= 1'b0;
                    end else begin
                        dly_valid_reg[gi] <= dly_valid_reg[gi-1];
                        dly_last_reg[gi]  <= dly_last_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

`ifdef FFT_PAIR_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (err_next && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign align_err_cnt = err_cnt_reg;
`endif

    assign opa        = opa_reg;
    assign opb        = opb_reg;
    assign pair_valid = pair_valid_reg;
    assign pair_last  = pair_last_reg;
    assign sum_valid  = dly_valid_reg[CADD_LAT-1];
    assign sum_last   = dly_last_reg[CADD_LAT-1];
    assign align_err  = align_err_reg;

endmodule

// File: tb/tb_fft_pair_gen.sv
// Directed bench for fft_pair_gen (N=8): frame-level reference model checked every cycle,
// plus literal pair/sum expectations per scenario.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

module tb_fft_pair_gen;
    localparam int N    = 8;
    localparam int HALF = N / 2;
    localparam int SW   = 2 * `FFT_DATA_WIDTH;

    logic          clk;
    logic          rst;
    logic [SW-1:0] in_data;
    logic          in_valid;
    logic          in_sop;
    logic [SW-1:0] opa, opb;
    logic          pair_valid, pair_last, sum_valid, sum_last, align_err;

    int checks = 0;
    int errors = 0;

    fft_pair_gen #(.FFT_SIZE(N), .CADD_LAT(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .opa(opa), .opb(opb), .pair_valid(pair_valid), .pair_last(pair_last),
        .sum_valid(sum_valid), .sum_last(sum_last), .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: current frame as a list of samples, outputs as plain values.
    logic [SW-1:0] fr[$];
    logic [SW-1:0] e_opa, e_opb;
    logic e_pv, e_pl, e_err, d0v, d0l, d1v, d1l;

    // Observations for the literal checks.
    int cap_a[$];
    int cap_b[$];
    int cap_last[$];
    int err_pulses;
    int sum_cnt;

    initial begin
        e_opa = '0; e_opb = '0;
        {e_pv, e_pl, e_err, d0v, d0l, d1v, d1l} = '0;
        err_pulses = 0;
        sum_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fr.delete();
                e_opa = '0; e_opb = '0;
                {e_pv, e_pl, e_err, d0v, d0l, d1v, d1l} = '0;
            end else begin
                d1v = d0v; d1l = d0l;
                d0v = e_pv; d0l = e_pl;
                e_pv = 1'b0; e_pl = 1'b0; e_err = 1'b0;
                if (in_valid) begin
                    if (in_sop) begin
                        if (fr.size() != 0) e_err = 1'b1;
                        fr.delete();
                        fr.push_back(in_data);
                    end else if (fr.size() == 0) begin
                        e_err = 1'b1;
                    end else begin
                        fr.push_back(in_data);
                        if (fr.size() > HALF) begin
                            e_pv  = 1'b1;
                            e_opa = fr[fr.size() - 1 - HALF];
                            e_opb = in_data;
                            e_pl  = (fr.size() == N);
                            if (fr.size() == N) fr.delete();
                        end
                    end
                end
            end
            chk("opa", opa, e_opa);
            chk("opb", opb, e_opb);
            chk("pair_valid", 32'(pair_valid), 32'(e_pv));
            chk("pair_last", 32'(pair_last), 32'(e_pl));
            chk("sum_valid", 32'(sum_valid), 32'(d1v));
            chk("sum_last", 32'(sum_last), 32'(d1l));
            chk("align_err", 32'(align_err), 32'(e_err));
            if (!rst) begin
                if (pair_valid) begin
                    cap_a.push_back(int'(opa[SW-1:SW/2]));
                    cap_b.push_back(int'(opb[SW-1:SW/2]));
                    cap_last.push_back(int'(pair_last));
                    $display("pair a=%0d b=%0d last=%0b", opa[SW-1:SW/2], opb[SW-1:SW/2], pair_last);
                end
                if (align_err) err_pulses++;
                if (sum_valid) sum_cnt++;
            end
        end
    end

    task automatic send(input int r, input bit sop);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = {r[15:0], 16'h0000};
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
            in_sop   = 1'b0;
        end
    endtask

    task automatic frame(input int base, input int first, input int last_r);
        for (int r = first; r <= last_r; r++) send(base + r, (r == 1));
    endtask

    task automatic clear_caps();
        cap_a.delete(); cap_b.delete(); cap_last.delete();
        err_pulses = 0;
        sum_cnt = 0;
    endtask

    // Pairs for frame base+1..base+8 starting at capture index off.
    task automatic check_frame(input string tag, input int base, input int off);
        if (cap_a.size() < off + HALF) begin
            chk({tag, "_pair_count"}, 32'(cap_a.size()), 32'(off + HALF));
        end else begin
            for (int k = 0; k < HALF; k++) begin
                chk({tag, "_opa"}, 32'(cap_a[off+k]), 32'(base + 1 + k));
                chk({tag, "_opb"}, 32'(cap_b[off+k]), 32'(base + 5 + k));
                chk({tag, "_last"}, 32'(cap_last[off+k]), 32'(k == HALF - 1));
                chk({tag, "_cadd_sum"}, 32'(cap_a[off+k] + cap_b[off+k]), 32'(2 * base + 6 + 2 * k));
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        gap(2);

        // 1: contiguous frame
        clear_caps();
        frame(0, 1, 8);
        gap(5);
        chk("t1_count", 32'(cap_a.size()), 32'd4);
        check_frame("t1", 0, 0);
        chk("t1_sum_cnt", 32'(sum_cnt), 32'd4);
        chk("t1_err", 32'(err_pulses), 32'd0);

        // 2: gaps after samples 2 and 6
        clear_caps();
        frame(0, 1, 2); gap(3);
        frame(0, 3, 6); gap(3);
        frame(0, 7, 8); gap(5);
        chk("t2_count", 32'(cap_a.size()), 32'd4);
        check_frame("t2", 0, 0);

        // 3: back-to-back frames
        clear_caps();
        frame(0, 1, 8);
        frame(10, 1, 8);
        gap(5);
        chk("t3_count", 32'(cap_a.size()), 32'd8);
        check_frame("t3a", 0, 0);
        check_frame("t3b", 10, 4);
        chk("t3_err", 32'(err_pulses), 32'd0);
        chk("t3_sum_cnt", 32'(sum_cnt), 32'd8);

        // 4: stray sample out of idle, then a normal frame
        clear_caps();
        send(9, 1'b0);
        gap(2);
        chk("t4_err", 32'(err_pulses), 32'd1);
        chk("t4_no_pair", 32'(cap_a.size()), 32'd0);
        frame(0, 1, 8);
        gap(5);
        check_frame("t4", 0, 0);

        // 5: sop at sample 3 restarts with 21..28
        clear_caps();
        send(1, 1'b1);
        send(2, 1'b0);
        frame(20, 1, 8);
        gap(5);
        chk("t5_err", 32'(err_pulses), 32'd1);
        chk("t5_count", 32'(cap_a.size()), 32'd4);
        check_frame("t5", 20, 0);

        // 6: asynchronous reset mid-PAIR after pair (2,6)
        clear_caps();
        frame(0, 1, 6);
        gap(1);
        chk("t6_pre_count", 32'(cap_a.size()), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_opa", opa, 32'd0);
        chk("t6_rst_opb", opb, 32'd0);
        chk("t6_rst_pv", 32'(pair_valid), 32'd0);
        chk("t6_rst_sv", 32'(sum_valid), 32'd0);
        chk("t6_rst_sl", 32'(sum_last), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        clear_caps();
        frame(10, 1, 8);
        gap(5);
        chk("t6_count", 32'(cap_a.size()), 32'd4);
        check_frame("t6", 10, 0);
        chk("t6_err", 32'(err_pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
